// File: rtl/add_m_pack_param_if.sv
// Bus bundle for add_m_pack_param: start/busy/done handshake, shared BRAM read port and
// packed-output write port. master = the datapath, slave = the environment driving it.
interface add_m_pack_param_if #(
  parameter int unsigned ADDR_W = 9
);
  logic              start;
  logic              busy;
  logic              done;
  logic              read_base_sel;
  logic [ADDR_W-1:0] read_address;
  logic [63:0]       read_data;
  logic [ADDR_W-1:0] write_address;
  logic [63:0]       write_data;
  logic              write_en;

  modport master (
    input  start, read_data,
    output busy, done, read_base_sel, read_address, write_address, write_data, write_en
  );

  modport slave (
    output start, read_data,
    input  busy, done, read_base_sel, read_address, write_address, write_data, write_en
  );
endinterface

// File: rtl/add_m_pack_param.sv
// Saber encryption-side message-add / round / pack stage: v' + H1 - (m << (EP-1)), keep the
// top ET bits of each EP-bit result and bit-pack the stream LSB-first into 64-bit words.
module add_m_pack_param #(
  parameter int unsigned N      = 256,
  parameter int unsigned EP     = 10,
  parameter int unsigned ET     = 4,
  parameter int unsigned H1     = 4,
  parameter int unsigned ADDR_W = 9
) (
  input logic                clk,
  input logic                rst_n,
  add_m_pack_param_if.master bus
);

  localparam int unsigned VWords = N / 4;
  localparam int unsigned BeatW  = 4 * ET;
  localparam int unsigned AccW   = 64 + BeatW;
  localparam int unsigned FillW  = 8;
  localparam logic [15:0] LaneOnes = 16'((32'd1 << EP) - 32'd1);
  localparam logic [63:0] LaneMask = {4{LaneOnes}};

  typedef enum logic [2:0] {
    StIdle, StMsgAddr, StMsgLoad, StStream, StDrain, StDone
  } state_e;

  state_e            state_q;
  logic              busy_q, done_q;
  logic              rbs_q;
  logic [ADDR_W-1:0] raddr_q;
  logic [ADDR_W-1:0] blk_q;
  logic [ADDR_W-1:0] vaddr_q;
  logic [63:0]       msg_q;
  logic              beat_q;
  logic [AccW-1:0]   acc_q;
  logic [FillW-1:0]  fill_q;
  logic [ADDR_W-1:0] wr_cnt_q;
  logic              wen_q;
  logic [63:0]       wdata_q;
  logic [ADDR_W-1:0] waddr_q;

  // Bits above EP in each 16-bit lane carry no information.
  logic unused_lane_bits;
  assign unused_lane_bits = ^(bus.read_data & ~LaneMask);

  logic [EP-1:0]    lane_t [4];
  logic [BeatW-1:0] beat_bits;

  always_comb begin
    beat_bits = '0;
    for (int j = 0; j < 4; j++) begin
      lane_t[j] = bus.read_data[16*j +: EP] + EP'(H1) - (EP'(msg_q[j]) << (EP - 1));
      beat_bits[ET*j +: ET] = lane_t[j][EP-1 -: ET];
    end
  end

  logic             wr_now;
  logic [AccW-1:0]  acc_sh, acc_d;
  logic [FillW-1:0] fill_sh, fill_d;

  // Drain a full word first, then append the current beat above what remains.
  always_comb begin
    wr_now  = fill_q >= FillW'(64);
    acc_sh  = wr_now ? (acc_q >> 64) : acc_q;
    fill_sh = wr_now ? (fill_q - FillW'(64)) : fill_q;
    acc_d   = acc_sh;
    fill_d  = fill_sh;
    if (beat_q) begin
      acc_d  = acc_sh | (AccW'(beat_bits) << fill_sh);
      fill_d = fill_sh + FillW'(BeatW);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rbs_q    <= 1'b0;
      raddr_q  <= '0;
      blk_q    <= '0;
      vaddr_q  <= '0;
      msg_q    <= '0;
      beat_q   <= 1'b0;
      acc_q    <= '0;
      fill_q   <= '0;
      wr_cnt_q <= '0;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
      waddr_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;
      beat_q <= 1'b0;
      wen_q  <= wr_now;
      if (wr_now) begin
        wdata_q  <= acc_q[63:0];
        waddr_q  <= wr_cnt_q;
        wr_cnt_q <= wr_cnt_q + ADDR_W'(1);
      end
      if (beat_q) begin
        msg_q <= msg_q >> 4;
      end

      case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            state_q  <= StMsgAddr;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            rbs_q    <= 1'b1;
            raddr_q  <= '0;
            blk_q    <= '0;
            vaddr_q  <= '0;
            wr_cnt_q <= '0;
            acc_q    <= '0;
            fill_q   <= '0;
          end
        end
        StMsgAddr: state_q <= StMsgLoad;
        StMsgLoad: begin
          // The last v' beat of the previous block was consumed last cycle, so the
          // shifter is free to take the new message word here.
          msg_q   <= bus.read_data;
          rbs_q   <= 1'b0;
          raddr_q <= vaddr_q;
          state_q <= StStream;
        end
        StStream: begin
          beat_q  <= 1'b1;
          vaddr_q <= vaddr_q + ADDR_W'(1);
          raddr_q <= vaddr_q + ADDR_W'(1);
          if (vaddr_q[3:0] == 4'hf) begin
            if (vaddr_q == ADDR_W'(VWords - 1)) begin
              state_q <= StDrain;
            end else begin
              state_q <= StMsgAddr;
              rbs_q   <= 1'b1;
              raddr_q <= blk_q + ADDR_W'(1);
              blk_q   <= blk_q + ADDR_W'(1);
            end
          end
        end
        StDrain: begin
          if (!beat_q && fill_q == '0) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.read_base_sel = rbs_q;
  assign bus.read_address  = raddr_q;
  assign bus.write_en      = wen_q;
  assign bus.write_data    = wdata_q;
  assign bus.write_address = waddr_q;

endmodule

// File: tb/tb_add_m_pack_param.sv
// Bench for add_m_pack_param: three instances (ET = 3/4/6) share one BRAM image and are
// checked every cycle against a bit-stream model built directly from the coefficient list.
module tb_add_m_pack_param;
  localparam int N  = 256;
  localparam int AW = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_r = 1'b0;
  always #5 clk = ~clk;

  add_m_pack_param_if #(.ADDR_W(AW)) if0 ();
  add_m_pack_param_if #(.ADDR_W(AW)) if1 ();
  add_m_pack_param_if #(.ADDR_W(AW)) if2 ();

  add_m_pack_param #(.N(N), .EP(10), .ET(3), .H1(4), .ADDR_W(AW)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.master));
  add_m_pack_param #(.N(N), .EP(10), .ET(4), .H1(4), .ADDR_W(AW)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.master));
  add_m_pack_param #(.N(N), .EP(10), .ET(6), .H1(4), .ADDR_W(AW)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2.master));

  assign if0.start = start_r;
  assign if1.start = start_r;
  assign if2.start = start_r;

  logic [63:0] vmem [512];
  logic [63:0] mmem [512];

  // BRAM with one cycle of read latency, one port per instance.
  always @(posedge clk) begin
    if0.read_data <= if0.read_base_sel ? mmem[if0.read_address] : vmem[if0.read_address];
    if1.read_data <= if1.read_base_sel ? mmem[if1.read_address] : vmem[if1.read_address];
    if2.read_data <= if2.read_base_sel ? mmem[if2.read_address] : vmem[if2.read_address];
  end

  logic [2:0]    wen, bsy, dne, rbs;
  logic [AW-1:0] wad [3];
  logic [AW-1:0] rad [3];
  logic [63:0]   wdat [3];
  assign wen = {if2.write_en, if1.write_en, if0.write_en};
  assign bsy = {if2.busy, if1.busy, if0.busy};
  assign dne = {if2.done, if1.done, if0.done};
  assign rbs = {if2.read_base_sel, if1.read_base_sel, if0.read_base_sel};
  assign wad[0] = if0.write_address;
  assign wad[1] = if1.write_address;
  assign wad[2] = if2.write_address;
  assign rad[0] = if0.read_address;
  assign rad[1] = if1.read_address;
  assign rad[2] = if2.read_address;
  assign wdat[0] = if0.write_data;
  assign wdat[1] = if1.write_data;
  assign wdat[2] = if2.write_data;

  int   ets [3] = '{3, 4, 6};
  int   vcoef [N];
  logic mbit [N];
  int   checks, errors, cyc;
  int   wcnt [3];
  int   vfirst [N/4];
  bit   in_run, in_reset;

  function automatic int total(input int i);
    return N * ets[i] / 64;
  endfunction

  // Expected output word w: walk the packed stream bit by bit from the coefficient list.
  function automatic logic [63:0] model_word(input int et, input int w);
    logic [63:0] word;
    word = '0;
    for (int b = 0; b < 64; b++) begin
      int s, k, t, r;
      s = 64 * w + b;
      k = s / et;
      t = (vcoef[k] + 4 + 1024 - (mbit[k] ? 512 : 0)) % 1024;
      r = t >> (10 - et);
      word[b] = r[s % et];
    end
    return word;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load(input int mode);
    for (int k = 0; k < N; k++) begin
      case (mode)
        0: begin vcoef[k] = 0;    mbit[k] = 1'b0; end
        1: begin vcoef[k] = 60;   mbit[k] = 1'b0; end
        2: begin vcoef[k] = 0;    mbit[k] = 1'b1; end
        3: begin vcoef[k] = 1020; mbit[k] = 1'b0; end
        default: begin
          vcoef[k] = (k * 4) % 1024;
          mbit[k]  = 1'($urandom_range(0, 1));
        end
      endcase
    end
    for (int w = 0; w < N/4; w++) begin
      logic [63:0] word;
      word = '0;
      // Junk in the unused upper lane bits must not leak into the result.
      for (int j = 0; j < 4; j++) word[16*j +: 16] = {6'h2b, vcoef[4*w+j][9:0]};
      vmem[w] = word;
    end
    for (int b = 0; b < N/64; b++)
      for (int j = 0; j < 64; j++) mmem[b][j] = mbit[64*b+j];
  endtask

  task automatic compare();
    for (int i = 0; i < 3; i++) begin
      if (in_reset) begin
        chk($sformatf("dut%0d write during reset", i), 64'(wen[i]), 64'd0);
      end else if (wen[i]) begin
        chk($sformatf("dut%0d write count bound", i), 64'(wcnt[i] < total(i)), 64'd1);
        if (wcnt[i] < total(i)) begin
          chk($sformatf("dut%0d write_address", i), 64'(wad[i]), 64'(wcnt[i]));
          chk($sformatf("dut%0d write_data w%0d", i, wcnt[i]), wdat[i],
              model_word(ets[i], wcnt[i]));
        end
        wcnt[i]++;
      end
      if (in_run) chk($sformatf("dut%0d busy^done", i), 64'(bsy[i] ^ dne[i]), 64'd1);
    end
    if (bsy[0] && !rbs[0] && rad[0] < AW'(N/4) && vfirst[rad[0]] < 0) vfirst[rad[0]] = cyc;
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s dut%0d ctl", tag, i),
          64'({rbs[i], rad[i], wad[i], wen[i], bsy[i], dne[i]}), 64'd0);
      chk($sformatf("%s dut%0d write_data", tag, i), wdat[i], 64'd0);
    end
  endtask

  task automatic run(input string tag, input int abort_at, input int pulse_at);
    bit finished;
    for (int i = 0; i < 3; i++) wcnt[i] = 0;
    for (int a = 0; a < N/4; a++) vfirst[a] = -1;
    cyc = 0;
    start_r = 1'b1;
    step();
    start_r = 1'b0;
    in_run = 1'b1;
    finished = 1'b0;
    for (int c = 1; c <= 300 && !finished; c++) begin
      if (c == pulse_at) start_r = 1'b1;
      if (c == abort_at) begin
        in_run = 1'b0;
        rst_n = 1'b0;
        #1;
        check_zero({tag, " abort"});
        in_reset = 1'b1;
        repeat (4) step();
        rst_n = 1'b1;
        in_reset = 1'b0;
        return;
      end
      step();
      start_r = 1'b0;
      finished = &dne;
    end
    chk({tag, " done reached"}, 64'(finished), 64'd1);
    repeat (6) step();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s dut%0d write total", tag, i), 64'(wcnt[i]), 64'(total(i)));
      chk($sformatf("%s dut%0d done held", tag, i), 64'(dne[i]), 64'd1);
    end
    for (int a = 1; a < N/4; a++)
      chk($sformatf("%s v' read spacing %0d", tag, a), 64'(vfirst[a] - vfirst[a-1]),
          (a % 16 == 0) ? 64'd3 : 64'd1);
    in_run = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    in_run = 1'b0;
    in_reset = 1'b0;
    load(0);
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    step();
    step();

    chk("pin et4 zeros", model_word(4, 0), 64'd0);
    run("zeros", 0, 0);

    load(1);
    chk("pin et4 v60", model_word(4, 7), 64'h1111111111111111);
    run("v60", 0, 0);

    load(2);
    chk("pin et4 m1", model_word(4, 3), 64'h8888888888888888);
    chk("pin et3 m1 w0", model_word(3, 0), 64'h4924924924924924);
    chk("pin et3 m1 w1", model_word(3, 1), 64'h2492492492492492);
    chk("pin et6 m1 w0", model_word(6, 0), 64'h0820820820820820);
    run("m1", 0, 0);

    load(3);
    chk("pin et4 wrap", model_word(4, 0), 64'd0);
    run("wrap", 0, 0);

    load(4);
    run("ramp", 0, 0);
    run("abort", 30, 0);
    run("rerun", 0, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/add_m_pack_param.md
Name: add_m_pack_param

Overview:
- Parametrised successor to the encryption-side message-add/round/pack stage of the Saber datapath.
- Reads v' coefficients (four per 64-bit BRAM word) and message bits from shared BRAM.
- Computes ((v' + H1 - (m << (EP-1))) mod 2^EP) >> (EP-ET) per coefficient and bit-packs the ET-bit results into 64-bit words.
- Supports LightSaber/Saber/FireSaber (ET = 3/4/6) through one RTL, including packed fields straddling word boundaries; start/busy/done handshake.

Parameters:
- N, 256, coefficients per polynomial; must be a multiple of 64, and N*ET a multiple of 64.
- EP, 10, modulus-p bit width; EP <= 16.
- ET, 4, output coefficient width; 1 <= ET < EP.
- H1, 4, rounding constant added to every coefficient (EP bits).
- ADDR_W, 9, BRAM address width.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins a run when idle or done.
- read_base_sel  output  1  0 = v' region, 1 = message region (external base mux).
- read_address  output  ADDR_W  word offset within the selected region.
- read_data  input  64  BRAM data, valid exactly 1 cycle after address.
- write_address  output  ADDR_W  packed-output word index, 0..N*ET/64-1.
- write_data  output  64  packed output word.
- write_en  output  1  write strobe, one cycle per output word.
- busy  output  1  high from the cycle after accepted start until done.
- done  output  1  high after final write until next start or reset.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - All address and beat counters, the bit accumulator and its fill count cleared.
  - All outputs 0.
- Reset mid-run aborts immediately; no further writes occur.
- Lane mapping: coefficient k is in v' word k/4, bits [16*(k%4)+EP-1 : 16*(k%4)]; upper lane bits are ignored. Message bit k is message word k/64, bit k%64.
- Arithmetic: t = (v + H1 - (m<<(EP-1))) truncated to EP bits (wrap mod 2^EP); r = t[EP-1:EP-ET].
- Packing: r_k occupies packed-stream bits [ET*k+ET-1 : ET*k], LSB-first. Output word w = stream bits [64w+63 : 64w].
- Accumulator: width >= 64+4*ET. Each v' word appends 4*ET bits above the current fill. When fill >= 64:
  - the low 64 bits are written;
  - the accumulator shifts right 64;
  - fill -= 64.
  - At most one write per cycle.
- FSM states:
  - IDLE: start -> MSG_ADDR.
  - MSG_ADDR: read_base_sel=1, read_address=k/64.
  - MSG_LOAD: latch read_data into the 64-bit message shifter.
  - STREAM: one v' address per cycle; the shifter shifts by 4 per processed word. After the 16th word of a message block -> MSG_ADDR if coefficients remain, else DRAIN.
  - DRAIN: wait for the last data beat and final write.
  - DONE: done=1; start -> MSG_ADDR with all counters cleared.
- start is ignored while busy.
- The pipeline is read-latency 1. The message reload costs 2 bubble cycles per 64 coefficients.
- Total writes are exactly N*ET/64, with strictly incrementing addresses. Fill is 0 at DONE.
- write_data and write_address are stable while write_en=1; write_en is never asserted in IDLE or DONE.

Test Plan:
- ET=4, all v'=0, all m=0 -> t=4, r=0; 16 writes of 0x0 at addresses 0..15; done asserts; write_en never high again.
- ET=4, all v'=60, m=0 -> t=64, r=1; every word 0x1111111111111111.
- ET=4, all v'=0, all m=1 -> t=(4-512) mod 1024=516, r=8; every word 0x8888888888888888. Also v'=1020, m=0 -> wrap to t=0, r=0.
- ET=3, all v'=0, m=1 -> r=516>>7=4; 12 writes. Word 0 = 0x4924924924924924 (bit 63 = LSB of r_21, which straddles the boundary). Verify straddle continuity across all words.
- ET=6, ramp v'[k]=k*4 mod 1024, random message -> 24 writes matching the C reference model bit-exactly. Also check 2-cycle bubbles at k=64,128,192.
- Reset pulsed low mid-STREAM -> outputs 0 immediately, no writes. A new start then reproduces the full correct run; start pulsed during busy has no effect.
